// File: rtl/synchro_generator_if.sv
// ---------------------------------------------------------------------------
// synchro_generator_if
// Purpose : Bundles the control and status signals of the programmable
//           square-wave source so that the generator and its driver can be
//           connected through a single port.
// Signals :
//   enable    run request (level); 1 = run, 0 = stop after the current period
//   high_len  high level length minus 1
//   low_len   low level length minus 1
//   burst     periods per burst, 0 = continuous
//   load      1-cycle strobe capturing high_len/low_len/burst
//   ack       1-cycle pulse when newly loaded settings become active
//   out       generated waveform (registered)
//   rise      1-cycle pulse in the first cycle out is high
//   done      1-cycle pulse when a burst completes
//   busy      1 while the generator is not idle
// Modports: master drives the controls, slave is the generator itself.
// ---------------------------------------------------------------------------
interface synchro_generator_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic [WIDTH-1:0] high_len;
    logic [WIDTH-1:0] low_len;
    logic [WIDTH-1:0] burst;
    logic             load;
    logic             ack;
    logic             out;
    logic             rise;
    logic             done;
    logic             busy;

    modport master (
        output enable, high_len, low_len, burst, load,
        input  ack, out, rise, done, busy
    );

    modport slave (
        input  enable, high_len, low_len, burst, load,
        output ack, out, rise, done, busy
    );
endinterface

// File: rtl/synchro_generator.sv
// ---------------------------------------------------------------------------
// synchro_generator
// Purpose : Programmable square-wave source. Drives out high for high_len+1
//           clocks and low for low_len+1 clocks. Settings are double
//           buffered and only take effect on a period boundary (last cycle
//           of LOW) or immediately while idle, so out never glitches.
// Ports   :
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    synchro_generator_if.slave (enable, high_len, low_len, burst,
//          load in; ack, out, rise, done, busy out)
// Configuration:
//   SYNCHRO_GENERATOR_BURST_EN  when defined, a burst of 'burst' periods is
//          emitted and then the generator stops with a done pulse. When not
//          defined the burst value is ignored, there is no period counter,
//          the output runs continuously and done is tied low.
// ---------------------------------------------------------------------------
module synchro_generator #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    synchro_generator_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] actHigh_q,  actHigh_d;
    logic [WIDTH-1:0] actLow_q,   actLow_d;
    logic [WIDTH-1:0] shHigh_q,   shHigh_d;
    logic [WIDTH-1:0] shLow_q,    shLow_d;
    logic [WIDTH-1:0] cnt_q,      cnt_d;
    logic             pending_q,  pending_d;
    logic             out_q,      out_d;
    logic             rise_q,     rise_d;
    logic             ack_q,      ack_d;
    logic             burstReached;
`ifdef SYNCHRO_GENERATOR_BURST_EN
    logic [WIDTH-1:0] actBurst_q, actBurst_d;
    logic [WIDTH-1:0] shBurst_q,  shBurst_d;
    logic [WIDTH-1:0] period_q,   period_d;
    logic             done_q,     done_d;
`else
    logic [WIDTH-1:0] unusedBurst;
    assign unusedBurst = bus.burst;
`endif

    // Next-state logic. Settings arriving while running go to the shadow set
    // and are flagged pending; at the boundary a load in that very cycle takes
    // priority over the shadow. The burst decision uses the settings that
    // governed the period that is ending.
    always_comb begin
        state_d      = state_q;
        actHigh_d    = actHigh_q;
        actLow_d     = actLow_q;
        shHigh_d     = shHigh_q;
        shLow_d      = shLow_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        ack_d        = 1'b0;
        burstReached = 1'b0;
`ifdef SYNCHRO_GENERATOR_BURST_EN
        actBurst_d   = actBurst_q;
        shBurst_d    = shBurst_q;
        period_d     = period_q;
        done_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shHigh_d  = bus.high_len;
                    shLow_d   = bus.low_len;
                    actHigh_d = bus.high_len;
                    actLow_d  = bus.low_len;
`ifdef SYNCHRO_GENERATOR_BURST_EN
                    shBurst_d  = bus.burst;
                    actBurst_d = bus.burst;
`endif
                    ack_d     = 1'b1;
                end
                if (bus.enable) begin
                    state_d  = HIGH;
                    cnt_d    = '0;
`ifdef SYNCHRO_GENERATOR_BURST_EN
                    period_d = '0;
`endif
                end
            end
            HIGH: begin
                if (bus.load) begin
                    shHigh_d  = bus.high_len;
                    shLow_d   = bus.low_len;
`ifdef SYNCHRO_GENERATOR_BURST_EN
                    shBurst_d = bus.burst;
`endif
                    pending_d = 1'b1;
                end
                if (cnt_q == actHigh_q) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + WIDTH'(1);
                end
            end
            LOW: begin
                if (cnt_q != actLow_q) begin
                    if (bus.load) begin
                        shHigh_d  = bus.high_len;
                        shLow_d   = bus.low_len;
`ifdef SYNCHRO_GENERATOR_BURST_EN
                        shBurst_d = bus.burst;
`endif
                        pending_d = 1'b1;
                    end
                    cnt_d = cnt_q + WIDTH'(1);
                end else begin
                    cnt_d = '0;
`ifdef SYNCHRO_GENERATOR_BURST_EN
                    burstReached = (actBurst_q != '0) &&
                                   ((period_q + WIDTH'(1)) == actBurst_q);
                    period_d     = period_q + WIDTH'(1);
`endif
                    if (bus.load) begin
                        shHigh_d  = bus.high_len;
                        shLow_d   = bus.low_len;
                        actHigh_d = bus.high_len;
                        actLow_d  = bus.low_len;
`ifdef SYNCHRO_GENERATOR_BURST_EN
                        shBurst_d  = bus.burst;
                        actBurst_d = bus.burst;
                        period_d   = '0;
`endif
                        pending_d = 1'b0;
                        ack_d     = 1'b1;
                    end else if (pending_q) begin
                        actHigh_d = shHigh_q;
                        actLow_d  = shLow_q;
`ifdef SYNCHRO_GENERATOR_BURST_EN
                        actBurst_d = shBurst_q;
                        period_d   = '0;
`endif
                        pending_d = 1'b0;
                        ack_d     = 1'b1;
                    end
                    if (burstReached) begin
                        state_d = IDLE;
`ifdef SYNCHRO_GENERATOR_BURST_EN
                        done_d  = 1'b1;
`endif
                    end else if (!bus.enable) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HIGH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        out_d  = (state_d == HIGH);
        rise_d = (state_d == HIGH) && (state_q != HIGH);
    end

    // State and output registers; reset abandons any period in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            actHigh_q <= '0;
            actLow_q  <= '0;
            shHigh_q  <= '0;
            shLow_q   <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            out_q     <= 1'b0;
            rise_q    <= 1'b0;
            ack_q     <= 1'b0;
`ifdef SYNCHRO_GENERATOR_BURST_EN
            actBurst_q <= '0;
            shBurst_q  <= '0;
            period_q   <= '0;
            done_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            actHigh_q <= actHigh_d;
            actLow_q  <= actLow_d;
            shHigh_q  <= shHigh_d;
            shLow_q   <= shLow_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            ack_q     <= ack_d;
`ifdef SYNCHRO_GENERATOR_BURST_EN
            actBurst_q <= actBurst_d;
            shBurst_q  <= shBurst_d;
            period_q   <= period_d;
            done_q     <= done_d;
`endif
        end
    end

    assign bus.out  = out_q;
    assign bus.rise = rise_q;
    assign bus.ack  = ack_q;
    assign bus.busy = (state_q != IDLE);
`ifdef SYNCHRO_GENERATOR_BURST_EN
    assign bus.done = done_q;
`else
    assign bus.done = 1'b0;
`endif

endmodule

// File: tb/tb_synchro_generator.sv
// ---------------------------------------------------------------------------
// tb_synchro_generator
// Purpose : Self-checking bench for synchro_generator. A period-position
//           reference model predicts out/rise/ack/done/busy every cycle for
//           directed scenarios and a long randomized run.
// Configuration: honours SYNCHRO_GENERATOR_BURST_EN like the design.
// ---------------------------------------------------------------------------
module tb_synchro_generator;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    synchro_generator_if #(.WIDTH(WIDTH)) bus ();

    synchro_generator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model: running flag, position within the current period,
    // active/shadow settings and completed-period count.
    bit running, pend;
    int pos, periodsDone;
    int aH, aL, aB, sH, sL, sB;
    bit eOut, eRise, eAck, eDone, eBusy;

    // Observed pulse tallies used by the directed scenarios.
    int riseSeen, ackSeen, doneSeen;

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advances the reference model by one clock edge with the given inputs.
    task automatic modelStep(input bit rstN, input bit en, input bit ld,
                             input int h, input int l, input int b);
        int periodLen;
        bit reached;
        eAck  = 1'b0;
        eDone = 1'b0;
        eRise = 1'b0;
        if (!rstN) begin
            running = 0; pend = 0; pos = 0; periodsDone = 0;
            aH = 0; aL = 0; aB = 0; sH = 0; sL = 0; sB = 0;
        end else if (!running) begin
            if (ld) begin
                aH = h; aL = l; aB = b; sH = h; sL = l; sB = b;
                eAck = 1'b1;
            end
            if (en) begin
                running = 1; pos = 0; periodsDone = 0; eRise = 1'b1;
            end
        end else begin
            periodLen = aH + aL + 2;
            if (pos != periodLen - 1) begin
                if (ld) begin
                    sH = h; sL = l; sB = b; pend = 1;
                end
                pos++;
            end else begin
                periodsDone++;
`ifdef SYNCHRO_GENERATOR_BURST_EN
                reached = (aB != 0) && (periodsDone == aB);
`else
                reached = 1'b0;
`endif
                if (ld) begin
                    aH = h; aL = l; aB = b; sH = h; sL = l; sB = b;
                    pend = 0; eAck = 1'b1; periodsDone = 0;
                end else if (pend) begin
                    aH = sH; aL = sL; aB = sB;
                    pend = 0; eAck = 1'b1; periodsDone = 0;
                end
                if (reached) begin
                    running = 0; eDone = 1'b1;
                end else if (!en) begin
                    running = 0;
                end else begin
                    pos = 0; eRise = 1'b1;
                end
            end
        end
        eOut  = running && (pos <= aH);
        eBusy = running;
    endtask

    // Drives one cycle of inputs, steps the model and checks every output.
    task automatic applyStimulus(input bit rstN, input bit en, input bit ld,
                                 input int h, input int l, input int b);
        rst_n        = rstN;
        bus.enable   = en;
        bus.load     = ld;
        bus.high_len = WIDTH'(h);
        bus.low_len  = WIDTH'(l);
        bus.burst    = WIDTH'(b);
        @(posedge clk);
        modelStep(rstN, en, ld, h, l, b);
        #1;
        checkOutput("out",  {31'd0, bus.out},  {31'd0, eOut});
        checkOutput("rise", {31'd0, bus.rise}, {31'd0, eRise});
        checkOutput("ack",  {31'd0, bus.ack},  {31'd0, eAck});
        checkOutput("done", {31'd0, bus.done}, {31'd0, eDone});
        checkOutput("busy", {31'd0, bus.busy}, {31'd0, eBusy});
        riseSeen += int'(bus.rise);
        ackSeen  += int'(bus.ack);
        doneSeen += int'(bus.done);
    endtask

    task automatic clearTallies();
        riseSeen = 0; ackSeen = 0; doneSeen = 0;
    endtask

    initial begin
        bit en;
        bit ld;
        bit rn;
        int h, l, b;
        int expDone;

        // Reset and idle state.
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Load H=3 L=1 while idle, then run: 4 high / 2 low, rise every 6.
        clearTallies();
        applyStimulus(1, 0, 1, 3, 1, 0);
        for (int i = 0; i < 24; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("t1_rises", riseSeen, 4);
        checkOutput("t1_acks", ackSeen, 1);

        // Mid-HIGH load of H=0 L=0: current period unaffected, then clk/2.
        clearTallies();
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("t2_acks", ackSeen, 1);

        // Two loads within one period: only the second is applied, one ack.
        clearTallies();
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 3, 1, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 5, 1, 0);
        applyStimulus(1, 1, 1, 2, 1, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("t3_acks", ackSeen, 2);

        // Burst of 3 periods at H=1 L=1.
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 1, 3);
        clearTallies();
        for (int i = 0; i < 12; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0, 0);
`ifdef SYNCHRO_GENERATOR_BURST_EN
        expDone = 1;
`else
        expDone = 0;
`endif
        checkOutput("t4_rises", riseSeen, 3);
        checkOutput("t4_done", doneSeen, expDone);
        checkOutput("t4_busy", {31'd0, bus.busy}, 32'd0);

        // Enable dropped during HIGH of H=4 L=4: full period still completes.
        applyStimulus(1, 0, 1, 4, 4, 0);
        clearTallies();
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("t5_rises", riseSeen, 1);

        // Reset in the middle of LOW, then run with cleared settings.
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, 0, 0);

        // Randomized traffic against the reference model.
        en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            ld = ($urandom_range(0, 11) == 0);
            rn = ($urandom_range(0, 199) != 0);
            h  = int'($urandom_range(0, 4));
            l  = int'($urandom_range(0, 4));
            b  = int'($urandom_range(0, 4));
            applyStimulus(rn, en, ld, h, l, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/synchro_generator.md
# synchro_generator

Programmable square-wave source, the transmit counterpart of the level-duration measurement path: drives `out` high for `high_len+1` clocks and low for `low_len+1` clocks, so a duration counter on the far end reads back exactly the programmed values. Used for the probe-compensation/calibration output and for loopback self-test of the measurement chain. Settings are double-buffered and applied only on period boundaries, so `out` never glitches. Optional burst mode emits a fixed number of periods, then stops.

## Interface
- `WIDTH`, 16: width of level-length and burst counters.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  level; 1 = run, 0 = stop at end of current period.
- `high_len`  in  WIDTH  high level length minus 1.
- `low_len`  in  WIDTH  low level length minus 1.
- `burst`  in  WIDTH  periods per burst; 0 = continuous.
- `load`  in  1  1-cycle strobe; captures `high_len`/`low_len`/`burst` into shadow.
- `ack`  out  1  1-cycle pulse when shadow values become active.
- `out`  out  1  generated waveform, registered.
- `rise`  out  1  1-cycle pulse in the first cycle `out` is high.
- `done`  out  1  1-cycle pulse when a burst completes.
- `busy`  out  1  1 while state is not IDLE.

## Operation
- States: IDLE (`out`=0), HIGH (`out`=1), LOW (`out`=0). Registers: active set, shadow set, `pending` flag, level counter, period counter.
- Reset (`rst_n`=0 at a clock edge): state IDLE; active and shadow sets all 0; `pending`, `out`, `rise`, `ack`, `done`, `busy` = 0; counters = 0. Applies mid-period; no completion of the period.
- `load` in IDLE: shadow captured and applied to active on the same edge; `ack`=1 the next cycle.
- `load` in HIGH/LOW: shadow captured, `pending`=1. A second `load` before the boundary overwrites shadow; one `ack` only.
- Period boundary = last cycle of LOW. At boundary: if `pending` (or `load` in this same cycle, which bypasses shadow and wins) -> active := new set, `pending` := 0, `ack` pulse; period counter resets to 0 on apply.
- IDLE -> HIGH when `enable`=1; level counter := 0, period counter := 0.
- HIGH: counter increments; when counter == active `high_len` -> LOW, counter := 0.
- LOW: counter increments; when counter == active `low_len` -> boundary decision, in priority: burst reached -> IDLE + `done`; `enable`=0 -> IDLE; else HIGH.
- Burst reached: active `burst` != 0 and completed periods (including the one ending now) == `burst`. Period counter is WIDTH bits, does not wrap before reaching `burst`.
- `enable` falling during HIGH/LOW: current period finishes fully; no truncation.
- Lengths 0 legal: level lasts 1 clock. Max level = 2^WIDTH clocks. `high_len`=`low_len`=0 gives clk/2.

## Timing
- `enable` sampled 1 at edge k in IDLE -> `out`=1 and `rise`=1 after edge k.
- HIGH lasts exactly `high_len`+1 cycles, LOW exactly `low_len`+1; period = `high_len`+`low_len`+2, no idle cycle between periods.
- `ack` and `done` assert the cycle after the boundary edge, i.e. together with the new HIGH (or IDLE); new values govern that HIGH.
- `busy` falls the same edge `out` enters IDLE.
- Inputs `high_len`/`low_len`/`burst` are don't-care except in cycles with `load`=1.

## Configuration
- `SYNCHRO_GENERATOR_BURST_EN` defined: burst counting, period counter and `done` as above.
- Not defined: `burst` ignored, period counter removed, always continuous, `done` tied 0; all other behaviour identical.

## Test plan
- Reset, load H=3 L=1 B=0, enable=1 -> `out` 4 high / 2 low repeating, `rise` every 6 cycles, one `ack` after load.
- Running H=3 L=1, load H=0 L=0 mid-HIGH -> current period unchanged; `ack` with next rise; then `out` toggles every cycle.
- Two loads in one period (H=5, then H=2) -> single `ack`, H=2 applied.
- Burst B=3, H=1 L=1 (macro defined) -> exactly 3 periods (12 cycles), `done` once, `out`=0, `busy`=0; undefined -> continuous, `done` never.
- Drop `enable` during HIGH of H=4 L=4 -> full 10-cycle period completes, then IDLE.
- `rst_n`=0 mid-LOW -> next cycle all outputs 0, state IDLE; active set 0.
